// File: rtl/instruction_mem_loader.sv
// Streams 32-bit host words big-endian into a byte-addressed instruction image and holds
// the CPU in reset until the image is complete. Define LOADER_CHECKSUM_EN for a running XOR checksum output.
module instruction_mem_word #(
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [31:0]     data,
    output logic [3:0][7:0] bytes
);
    // bytes[0] is the lowest address of the slot, so it takes the most significant byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes <= {4{FILL_BYTE}};
        end else if (we) begin
            bytes[0] <= data[31:24];
            bytes[1] <= data[23:16];
            bytes[2] <= data[15:8];
            bytes[3] <= data[7:0];
        end
    end
endmodule

module instruction_mem_loader #(
    parameter int         MEM_BYTES = 256,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     in_word,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    input  logic                            reload,
    output logic [MEM_BYTES-1:0][7:0]       instruction_mem,
    output logic                            load_done,
    output logic                            cpu_reset,
    output logic [$clog2(MEM_BYTES/4):0]    word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                     checksum
`endif
);
    localparam int WORDS = MEM_BYTES / 4;
    localparam int WP_W  = $clog2(WORDS);

    typedef enum logic {LOAD, DONE} state_t;

    state_t          state, state_nxt;
    logic [WP_W-1:0] wptr;
    logic            accept;
    logic            wr;
    logic            last_slot;

    always_ff @(posedge clk) begin
        if (reset || reload) state <= LOAD;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == LOAD);
        accept    = in_valid && (state == LOAD);
        last_slot = (wptr == WP_W'(WORDS - 1));
        wr        = accept && !reload;
        if (wr && (in_last || last_slot)) state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (reset || reload) begin
            wptr       <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            cpu_reset  <= 1'b1;
        end else begin
            if (wr) begin
                wptr       <= wptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (state == LOAD && state_nxt == DONE) load_done <= 1'b1;
            // CPU is released one cycle after the image is declared complete.
            if (load_done) cpu_reset <= 1'b0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || reload) checksum <= '0;
        else if (wr)         checksum <= checksum ^ in_word;
    end
`endif

    genvar i;
    generate
        for (i = 0; i < WORDS; i++) begin : g_slot
            instruction_mem_word #(.FILL_BYTE(FILL_BYTE)) u_word (
                .clk   (clk),
                .reset (reset),
                .we    (wr && (wptr == WP_W'(i))),
                .data  (in_word),
                .bytes (instruction_mem[4*i+3 -: 4])
            );
        end
    endgenerate
endmodule

// File: tb/tb_instruction_mem_loader.sv
// Directed bench for instruction_mem_loader: vector table plus hand sequences for fill, reset and checksum.
module tb_instruction_mem_loader;
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      in_word = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             reload = 1'b0;
    logic [255:0][7:0] instruction_mem;
    logic             load_done;
    logic             cpu_reset;
    logic [6:0]       word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instruction_mem_loader #(.MEM_BYTES(256), .FILL_BYTE(8'h00)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_word         (in_word),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .reload          (reload),
        .instruction_mem (instruction_mem),
        .load_done       (load_done),
        .cpu_reset       (cpu_reset),
        .word_count      (word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum        (checksum)
`endif
    );

    typedef struct {
        logic        rst, rl, v, l;
        logic [31:0] w;
        logic        e_rdy, e_done, e_cpu;
        logic [6:0]  e_wc;
        int          addr;
        logic [31:0] e_mem;
    } vec_t;

    vec_t vec[17];

    function automatic vec_t mk(logic rst, logic rl, logic v, logic l, logic [31:0] w,
                                logic rdy, logic dn, logic cpu, logic [6:0] wc,
                                int addr, logic [31:0] m);
        vec_t t;
        t.rst = rst; t.rl = rl; t.v = v; t.l = l; t.w = w;
        t.e_rdy = rdy; t.e_done = dn; t.e_cpu = cpu; t.e_wc = wc;
        t.addr = addr; t.e_mem = m;
        return t;
    endfunction

    function automatic logic [31:0] memw(int a);
        return {instruction_mem[a], instruction_mem[a+1], instruction_mem[a+2], instruction_mem[a+3]};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic rl, logic v, logic l, logic [31:0] w);
        reset = rst; reload = rl; in_valid = v; in_last = l; in_word = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nonfill_count(int from);
        int c = 0;
        for (int a = from; a < 256; a++) if (instruction_mem[a] !== 8'h00) c++;
        return c;
    endfunction

    initial begin
        //               rst rl v  l  word           rdy dn cpu wc addr mem
        vec[0]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 1, 0, 0,  32'h00000000);
        vec[1]  = mk(0, 0, 1, 0, 32'h20080005,  1, 0, 1, 1, 0,  32'h20080005);
        vec[2]  = mk(0, 0, 1, 1, 32'h20090003,  0, 1, 1, 2, 4,  32'h20090003);
        vec[3]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 0, 2, 8,  32'h00000000);
        vec[4]  = mk(0, 0, 1, 1, 32'h11111111,  0, 1, 0, 2, 8,  32'h00000000);
        vec[5]  = mk(0, 1, 1, 0, 32'hDEADBEEF,  1, 0, 1, 0, 0,  32'h20080005);
        vec[6]  = mk(0, 0, 1, 0, 32'hA0A0A0A0,  1, 0, 1, 1, 0,  32'hA0A0A0A0);
        vec[7]  = mk(0, 0, 0, 0, 32'h0,         1, 0, 1, 1, 4,  32'h20090003);
        vec[8]  = mk(0, 1, 0, 0, 32'h0,         1, 0, 1, 0, 0,  32'hA0A0A0A0);
        vec[9]  = mk(0, 0, 1, 0, 32'h01020304,  1, 0, 1, 1, 0,  32'h01020304);
        vec[10] = mk(0, 0, 0, 0, 32'hFFFFFFFF,  1, 0, 1, 1, 4,  32'h20090003);
        vec[11] = mk(0, 0, 1, 0, 32'h05060708,  1, 0, 1, 2, 4,  32'h05060708);
        vec[12] = mk(0, 0, 0, 0, 32'hFFFFFFFF,  1, 0, 1, 2, 8,  32'h00000000);
        vec[13] = mk(0, 0, 1, 0, 32'h090A0B0C,  1, 0, 1, 3, 8,  32'h090A0B0C);
        vec[14] = mk(0, 0, 0, 0, 32'h0,         1, 0, 1, 3, 12, 32'h00000000);
        vec[15] = mk(0, 0, 1, 1, 32'h0D0E0F10,  0, 1, 1, 4, 12, 32'h0D0E0F10);
        vec[16] = mk(1, 1, 1, 0, 32'h12345678,  1, 0, 1, 0, 12, 32'h00000000);

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            drive(vec[i].rst, vec[i].rl, vec[i].v, vec[i].l, vec[i].w);
            step();
            check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vec[i].e_rdy));
            check($sformatf("v%0d_done", i),  32'(load_done), 32'(vec[i].e_done));
            check($sformatf("v%0d_cpu", i),   32'(cpu_reset), 32'(vec[i].e_cpu));
            check($sformatf("v%0d_wc", i),    32'(word_count), 32'(vec[i].e_wc));
            check($sformatf("v%0d_mem", i),   memw(vec[i].addr), vec[i].e_mem);
            if (i == 3) check("v3_tail_fill", nonfill_count(8), 0);
            #3;
        end

        // Fill all 64 slots without in_last; the last slot must end the load.
        drive(1, 0, 0, 0, 0); step(); #3;
        for (int k = 1; k <= 64; k++) begin
            drive(0, 0, 1, 0, 32'hC0000000 | k);
            step();
            if (k == 63 || k == 64) begin
                check($sformatf("full_ready_%0d", k), 32'(in_ready), (k == 64) ? 32'd0 : 32'd1);
                check($sformatf("full_done_%0d", k),  32'(load_done), (k == 64) ? 32'd1 : 32'd0);
            end
            #3;
        end
        drive(0, 0, 1, 1, 32'h55555555); step();
        check("full_wc", 32'(word_count), 32'd64);
        check("full_last_slot", memw(252), 32'hC0000040);
        check("full_first_slot", memw(0), 32'hC0000001);
        check("full_cpu_released", 32'(cpu_reset), 32'd0);
        #3;

        // Reset after two of five words throws away the partial image.
        drive(1, 0, 0, 0, 0); step(); #3;
        drive(0, 0, 1, 0, 32'hAAAA0001); step(); #3;
        drive(0, 0, 1, 0, 32'hAAAA0002); step(); #3;
        check("mid_wc_before", 32'(word_count), 32'd2);
        drive(1, 0, 1, 0, 32'hAAAA0003); step();
        check("mid_all_fill", nonfill_count(0), 0);
        check("mid_wc", 32'(word_count), 32'd0);
        check("mid_cpu", 32'(cpu_reset), 32'd1);
        check("mid_done", 32'(load_done), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        #3;

`ifdef LOADER_CHECKSUM_EN
        drive(0, 0, 1, 0, 32'h0000FFFF); step(); #3;
        drive(0, 0, 1, 1, 32'hFFFF0000); step();
        check("csum_xor", checksum, 32'hFFFFFFFF);
        #3;
        drive(0, 1, 0, 0, 0); step();
        check("csum_reload", checksum, 32'h0);
        #3;
`endif

        drive(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
